qs_mq: RTL and testbench

QS_MQ -- requirements
Module: qs_mq

---
 rtl/qs_mq_pkg.sv | 23 ++
 rtl/qs_mq_sat_cnt.sv | 35 +++
 rtl/qs_mq.sv | 127 ++++++++++++
 tb/tb_qs_mq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/qs_mq_pkg.sv
// Shared definitions for the queue-select metadata router.
// Packet types, metadata field positions and default token scaling.
package qs_mq_pkg;

    localparam logic [2:0] PT_BE         = 3'd0;
    localparam logic [2:0] PT_RC         = 3'd1;
    localparam logic [2:0] PT_RC_NOSHAPE = 3'd2;
    localparam logic [2:0] PT_TSN        = 3'd3;

    localparam int MD_W        = 24;
    localparam int MD_TYPE_MSB = 23;
    localparam int MD_TYPE_LSB = 21;
    localparam int MD_LEN_MSB  = 20;
    localparam int MD_LEN_LSB  = 9;
    localparam int MD_DESC_MSB = 8;
    localparam int MD_DESC_LSB = 0;

    localparam int LEN_W  = MD_LEN_MSB - MD_LEN_LSB + 1;
    localparam int DESC_W = MD_DESC_MSB - MD_DESC_LSB + 1;

    localparam int DEF_TOKEN_SHIFT = 4;

endpackage

// File: rtl/qs_mq_sat_cnt.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Ports: clk, rst_n (async, active-low), clr_i, inc_i, cnt_o[W].
module qs_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/qs_mq.sv
// Queue select: maps metadata to TSN/RC/BE queues, one registered stage.
// Ports: in_qs_* (slot, metadata, strobe, full flags, counter clear);
// out_qs_md {token,desc}, one-hot out_qs_md_wr, drop and invalid counters.
module qs_mq
    import qs_mq_pkg::*;
#(
    parameter int NUM_TS_Q    = 2,
    parameter int TOKEN_W     = 7,
    parameter int TOKEN_SHIFT = DEF_TOKEN_SHIFT,
    parameter int CNT_W       = 16,
    localparam int NQ         = NUM_TS_Q + 2,
    localparam int TS_W       = $clog2(NUM_TS_Q)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TS_W-1:0]         in_qs_time_slot,
    input  logic [MD_W-1:0]         in_qs_md,
    input  logic                    in_qs_md_wr,
    input  logic [NQ-1:0]           in_qs_q_full,
    input  logic                    in_qs_cnt_clr,
    output logic [DESC_W+TOKEN_W-1:0] out_qs_md,
    output logic [NQ-1:0]           out_qs_md_wr,
    output logic [NQ*CNT_W-1:0]     out_qs_drop_cnt,
    output logic [CNT_W-1:0]        out_qs_inv_cnt
);

    localparam int QW    = $clog2(NQ);
    localparam int OMD_W = DESC_W + TOKEN_W;
    localparam logic [31:0] TOK_MAX = (32'd1 << TOKEN_W) - 32'd1;

    logic [2:0]        pkt_type;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_sh;
    logic [DESC_W-1:0] desc;

    logic              type_ok;
    logic [QW-1:0]     tgt;
    logic              tgt_full;
    logic [TOKEN_W-1:0] tok;
    logic [NQ-1:0]     drop_vec;
    logic              inv_inc;

    logic [OMD_W-1:0]  md_d, md_q;
    logic [NQ-1:0]     wr_d, wr_q;

    assign pkt_type = in_qs_md[MD_TYPE_MSB:MD_TYPE_LSB];
    assign len      = in_qs_md[MD_LEN_MSB:MD_LEN_LSB];
    assign desc     = in_qs_md[MD_DESC_MSB:MD_DESC_LSB];
    assign len_sh   = len >> TOKEN_SHIFT;

    always_comb begin
        type_ok = 1'b1;
        tgt     = '0;
        unique case (pkt_type)
            PT_TSN:                tgt = QW'(in_qs_time_slot);
            PT_RC, PT_RC_NOSHAPE:  tgt = QW'(NUM_TS_Q);
            PT_BE:                 tgt = QW'(NUM_TS_Q + 1);
            default:               type_ok = 1'b0;
        endcase
    end

    // Shaped RC token: (len >> shift) - 2, clamped to [0, 2^TOKEN_W-1].
    always_comb begin
        tok = '0;
        if (pkt_type == PT_RC) begin
            if (len_sh < LEN_W'(2)) begin
                tok = '0;
            end else if ((32'(len_sh) - 32'd2) > TOK_MAX) begin
                tok = '1;
            end else begin
                tok = TOKEN_W'(len_sh - LEN_W'(2));
            end
        end
    end

    // Full flags are only consulted for valid types.
    assign tgt_full = in_qs_q_full[tgt];

    always_comb begin
        wr_d     = '0;
        md_d     = '0;
        drop_vec = '0;
        inv_inc  = 1'b0;
        if (in_qs_md_wr) begin
            if (!type_ok) begin
                inv_inc = 1'b1;
            end else if (tgt_full) begin
                drop_vec = NQ'(1) << tgt;
            end else begin
                wr_d = NQ'(1) << tgt;
                md_d = {tok, desc};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q <= '0;
            wr_q <= '0;
        end else begin
            md_q <= md_d;
            wr_q <= wr_d;
        end
    end

    assign out_qs_md    = md_q;
    assign out_qs_md_wr = wr_q;

    for (genvar q = 0; q < NQ; q++) begin : g_drop
        qs_sat_cnt #(.W(CNT_W)) u_drop (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (in_qs_cnt_clr),
            .inc_i (drop_vec[q]),
            .cnt_o (out_qs_drop_cnt[q*CNT_W +: CNT_W])
        );
    end

    qs_sat_cnt #(.W(CNT_W)) u_inv (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (in_qs_cnt_clr),
        .inc_i (inv_inc),
        .cnt_o (out_qs_inv_cnt)
    );

endmodule

// File: tb/tb_qs_mq.sv
// Directed bench for qs_mq (4 TSN slots, 2-bit counters).
// Drives at negedge, checks registered outputs at the following negedge.
module tb_qs_mq;

    localparam int NTS = 4;
    localparam int TW  = 7;
    localparam int CW  = 2;
    localparam int NQ  = NTS + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       slot = '0;
    logic [23:0]      md = '0;
    logic             md_wr = 1'b0;
    logic [NQ-1:0]    q_full = '0;
    logic             cnt_clr = 1'b0;
    logic [9+TW-1:0]  omd;
    logic [NQ-1:0]    owr;
    logic [NQ*CW-1:0] odrop;
    logic [CW-1:0]    oinv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    qs_mq #(
        .NUM_TS_Q    (NTS),
        .TOKEN_W     (TW),
        .TOKEN_SHIFT (4),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_qs_time_slot (slot),
        .in_qs_md        (md),
        .in_qs_md_wr     (md_wr),
        .in_qs_q_full    (q_full),
        .in_qs_cnt_clr   (cnt_clr),
        .out_qs_md       (omd),
        .out_qs_md_wr    (owr),
        .out_qs_drop_cnt (odrop),
        .out_qs_inv_cnt  (oinv)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [2:0] t, input logic [11:0] len,
                       input logic [8:0] d, input logic [1:0] s);
        md    = {t, len, d};
        slot  = s;
        md_wr = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_md",   32'(omd),   32'h0);
        check("rst_wr",   32'(owr),   32'h0);
        check("rst_drop", 32'(odrop), 32'h0);
        check("rst_inv",  32'(oinv),  32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // TSN slot 2
        drv(3'd3, 12'd64, 9'h1A5, 2'd2);
        tick();
        check("tsn_wr", 32'(owr), 32'b000100);
        check("tsn_md", 32'(omd), {16'h0, 7'd0, 9'h1A5});

        // RC token cases
        drv(3'd1, 12'd160, 9'h011, 2'd0);
        tick();
        check("rc160_wr", 32'(owr), 32'b010000);
        check("rc160_md", 32'(omd), {16'h0, 7'd8, 9'h011});
        drv(3'd1, 12'd16, 9'h022, 2'd0);
        tick();
        check("rc16_md", 32'(omd), {16'h0, 7'd0, 9'h022});
        drv(3'd1, 12'd4095, 9'h033, 2'd0);
        tick();
        check("rc4095_md", 32'(omd), {16'h0, 7'd127, 9'h033});
        drv(3'd2, 12'd4095, 9'h044, 2'd0);
        tick();
        check("rcns_wr", 32'(owr), 32'b010000);
        check("rcns_md", 32'(omd), {16'h0, 7'd0, 9'h044});

        // idle cycle
        md_wr = 1'b0;
        tick();
        check("idle_wr", 32'(owr), 32'h0);
        check("idle_md", 32'(omd), 32'h0);

        // BE queue full: drops, other queues unaffected
        q_full = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            drv(3'd0, 12'd100, 9'(i + 1), 2'd0);
            tick();
            check("be_drop_wr", 32'(owr), 32'h0);
            check("be_drop_md", 32'(omd), 32'h0);
            drv(3'd2, 12'd100, 9'h0F0, 2'd0);
            tick();
            check("rc_pass_wr", 32'(owr), 32'b010000);
        end
        drv(3'd3, 12'd100, 9'h0AB, 2'd1);
        tick();
        check("tsn_pass_wr", 32'(owr), 32'b000010);
        check("drop_cnt3", 32'(odrop), {20'h0, 2'd3, 10'h0});

        // invalid types ignore full flags; counter saturates at 3
        q_full = '1;
        drv(3'd5, 12'd100, 9'h055, 2'd0);
        tick();
        check("inv_wr", 32'(owr), 32'h0);
        check("inv_cnt1", 32'(oinv), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drv(3'd7, 12'd100, 9'h066, 2'd0);
            tick();
        end
        check("inv_sat", 32'(oinv), 32'd3);
        check("inv_nodrop", 32'(odrop), {20'h0, 2'd3, 10'h0});

        // clear coincident with a drop
        q_full  = 6'b100000;
        cnt_clr = 1'b1;
        drv(3'd0, 12'd100, 9'h077, 2'd0);
        tick();
        cnt_clr = 1'b0;
        check("clr_drop", 32'(odrop), 32'h0);
        check("clr_inv",  32'(oinv),  32'h0);
        q_full = '0;

        // back-to-back, slot alternating every cycle
        for (int i = 0; i < 6; i++) begin
            drv(3'd3, 12'd64, 9'(i + 8'h10), 2'(i % 2));
            tick();
            check("b2b_wr", 32'(owr), 32'(1 << (i % 2)));
            check("b2b_md", 32'(omd), 32'(i + 8'h10));
        end

        // async reset mid-burst
        drv(3'd2, 12'd64, 9'h1FF, 2'd0);
        q_full = 6'b000001;
        drv(3'd3, 12'd64, 9'h1FF, 2'd0);
        tick();
        check("pre_rst_wr", 32'(owr), 32'h0);
        check("pre_rst_drop", 32'(odrop), 32'd1);
        q_full = '0;
        drv(3'd2, 12'd64, 9'h1EE, 2'd0);
        tick();
        check("pre_rst_wr2", 32'(owr), 32'b010000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr",   32'(owr),   32'h0);
        check("arst_md",   32'(omd),   32'h0);
        check("arst_drop", 32'(odrop), 32'h0);
        md_wr = 1'b0;
        tick();
        rst_n = 1'b1;
        drv(3'd0, 12'd64, 9'h123, 2'd0);
        tick();
        check("post_rst_wr", 32'(owr), 32'b100000);
        check("post_rst_md", 32'(omd), {16'h0, 7'd0, 9'h123});
        md_wr = 1'b0;
        tick();
        check("post_rst_idle", 32'(owr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
